// File: rtl/sram22_1r1w_model.sv
// Behavioural 1R1W SRAM22 macro: lane-masked writes, write-first collision forwarding, read-valid strobe.
// Define SRAM22_OUTREG_EN to add a second output register stage (read latency 2).
module sram22_1r1w_model #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 10,
  parameter int WMASK_WIDTH = 4,
  parameter int RAM_DEPTH   = 1 << ADDR_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic [WMASK_WIDTH-1:0] wmask,
  input  logic [ADDR_WIDTH-1:0]  waddr,
  input  logic [DATA_WIDTH-1:0]  din,
  input  logic                   re,
  input  logic [ADDR_WIDTH-1:0]  raddr,
  output logic [DATA_WIDTH-1:0]  dout,
  output logic                   dout_valid
);

  localparam int LANE = DATA_WIDTH / WMASK_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(RAM_DEPTH);

  // Zero contents at time 0 so simulation never reads X from an unwritten word.
  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH] = '{default: '0};

  function automatic logic [DATA_WIDTH-1:0] lane_merge(
    input logic [DATA_WIDTH-1:0]  old_word,
    input logic [DATA_WIDTH-1:0]  new_word,
    input logic [WMASK_WIDTH-1:0] mask
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_word;
    for (int k = 0; k < WMASK_WIDTH; k++) begin
      if (mask[k]) res[k*LANE +: LANE] = new_word[k*LANE +: LANE];
    end
    return res;
  endfunction

  logic                  waddr_ok;
  logic                  raddr_ok;
  logic                  collide;
  logic [DATA_WIDTH-1:0] rd_word;

  assign waddr_ok = ({1'b0, waddr} < DEPTH_LIM);
  assign raddr_ok = ({1'b0, raddr} < DEPTH_LIM);
  assign collide  = we && (raddr == waddr);

  // Write-first: masked lanes of a same-address write overtake the stored word.
  always_comb begin
    rd_word = '0;
    if (raddr_ok) begin
      rd_word = mem[raddr];
      if (collide) rd_word = lane_merge(rd_word, din, wmask);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && we && waddr_ok) mem[waddr] <= lane_merge(mem[waddr], din, wmask);
  end

  // ---- stage p0: read result register ----
  logic [DATA_WIDTH-1:0] dout_p0;
  logic                  vld_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_p0 <= '0;
      vld_p0  <= 1'b0;
    end else begin
      vld_p0 <= re;
      if (re) dout_p0 <= rd_word;
    end
  end

`ifdef SRAM22_OUTREG_EN
  // ---- stage p1: optional output register ----
  logic [DATA_WIDTH-1:0] dout_p1;
  logic                  vld_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_p1 <= '0;
      vld_p1  <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) dout_p1 <= dout_p0;
    end
  end

  assign dout       = dout_p1;
  assign dout_valid = vld_p1;
`else
  assign dout       = dout_p0;
  assign dout_valid = vld_p0;
`endif

endmodule
